seq_pattern_tx: RTL and testbench
=================================

# seq_pattern_tx

Serial pattern transmitter: on a start request, shifts a latched PAT_W-bit pattern out MSB-first on a single-bit line, repeated a programmable number of times with a programmable idle gap between frames. It is the source end of the serial sequence-detection path and drives the detector's `din` input. It can run standalone or in bench loopback against the detector.

## Interface
- PAT_W, 4, pattern length in bits (≥2)
- PAT_DEF, 4'b1010, pattern used when `use_def`=1
- CNT_W, 8, width of repeat count
- GAP_W, 4, width of inter-frame gap count
- clk  input  1  rising-edge clock; only clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a burst; sampled in IDLE only
- abort  input  1  synchronous cancel of a burst in progress
- use_def  input  1  1: send PAT_DEF; 0: send pat_in
- pat_in  input  PAT_W  user pattern, latched at start
- rep_cnt  input  CNT_W  frames per burst, latched at start; 0 treated as 1
- gap_cnt  input  GAP_W  idle cycles between frames, latched at start
- dout  output  1  serial data; 0 when not sending
- valid  output  1  high while dout carries a pattern bit
- busy  output  1  high in SEND and GAP
- done  output  1  one-cycle pulse after the last bit of a completed burst

## Operation
- States: IDLE, SEND, GAP, DONE. All outputs are registered or decoded from registered state (Moore); no combinational input-to-output path.
- IDLE: dout=0, valid=0, busy=0, done=0.
  - start=1 and abort=0: latch pattern (PAT_DEF or pat_in), reps=max(rep_cnt,1), gap=gap_cnt; set bit index to PAT_W-1; go to SEND.
- SEND: dout=pat_q[idx], valid=1, busy=1. idx decrements each cycle. At idx=0:
  - reps_left=1 → DONE.
  - Otherwise, decrement reps_left. If gap=0 → SEND with idx=PAT_W-1 (back-to-back frames). Else → GAP with gap counter=gap.
- GAP: dout=0, valid=0, busy=1. Counter decrements each cycle; on the last gap cycle → SEND with idx=PAT_W-1.
- DONE: done=1, busy=0, valid=0 for exactly one cycle → IDLE.
- abort=1 in SEND or GAP → IDLE next edge. No done pulse; dout and valid go to 0 that edge.
- start outside IDLE is ignored. pat_in, rep_cnt and gap_cnt changes after the latch have no effect on the current burst.
- start and abort both high in IDLE: abort wins, and the block stays in IDLE.
- Async reset (rst_n=0), at any time including mid-burst: state=IDLE and dout, valid, busy, done = 0 immediately. All counters and the pattern register clear to 0.

## Timing
- start sampled high at edge k → first bit (MSB) on dout/valid during cycle k+1.
- Burst length: R·PAT_W + (R−1)·G cycles of busy, where R = reps and G = gap.
- done is asserted in the cycle immediately after the last valid bit.
- Earliest next start is the cycle after done, when the block is back in IDLE. Minimum spacing between bursts is therefore 1 idle cycle.
- Counter widths: reps is CNT_W bits and the gap counter is GAP_W bits. No wrap-around is possible, because they only decrement to their terminal value.

## Structure
- Shared package seq_pkg holds:
  - the state enum (IDLE=0, SEND=1, GAP=2, DONE=3, 2 bits);
  - the default 4'b1010 pattern constant, shared with the detector side.
- One natural sub-module: seq_down_cnt, a loadable down-counter with a terminal-count flag. It is instantiated three times: bit index, reps and gap.

## Test plan
- Default pattern, rep_cnt=1, gap_cnt=0, start pulse → dout 1,0,1,0 with valid high for 4 cycles, done one cycle later, busy high for 4 cycles.
- use_def=1, rep_cnt=3, gap_cnt=2 → dout 1010 00 1010 00 1010 (16 busy cycles, valid low during gaps), done once at the end.
- use_def=0, pat_in=4'b0110, rep_cnt=0 → single frame 0,1,1,0 (0 treated as 1), done pulse.
- abort asserted on the 3rd bit of frame 2 of a rep_cnt=4 burst → IDLE next edge, dout/valid/busy=0, no done. A new start then behaves normally.
- rst_n pulled low mid-GAP → all outputs 0 immediately. After release, start is accepted and the first bit appears the following cycle.
- Loopback: dout wired to the 1010 detector din, rep_cnt=5, gap_cnt=1 → detector fires exactly 5 times. start pulses while busy are ignored, and pat_in changes mid-burst do not alter the output.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM state encoding and default pattern for the serial sequence path
package seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;
  localparam logic [3:0] DEF_PAT = 4'b1010;
endpackage

// File: rtl/seq_down_cnt.sv
// seq_down_cnt: loadable down-counter with terminal-count flag
module seq_down_cnt #(
  parameter int W = 4,
  parameter int TC = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic [W-1:0] cnt,
  output logic         tc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (dec) cnt <= cnt - W'(1);
  assign tc = cnt == W'(TC);
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter with repeat count and inter-frame gap
module seq_pattern_tx import seq_pkg::*; #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_DEF = DEF_PAT,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             use_def,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_cnt,
  output logic             dout,
  output logic             valid,
  output logic             busy,
  output logic             done
);
  localparam int IW = $clog2(PAT_W);
  state_t state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [GAP_W-1:0] gap_q, gap_left;
  logic [CNT_W-1:0] reps_left;
  logic [IW-1:0] idx;
  logic idx_last, reps_last, gap_last, go, frame_end, unused_cnt;
  assign go = state_q == IDLE && start && !abort;
  assign frame_end = state_q == SEND && idx_last;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = go ? SEND : IDLE;
      SEND: state_d = abort ? IDLE : !idx_last ? SEND : reps_last ? DONE : gap_q == '0 ? SEND : GAP;
      GAP: state_d = abort ? IDLE : gap_last ? SEND : GAP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q <= '0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        pat_q <= use_def ? PAT_DEF : pat_in;
        gap_q <= gap_cnt;
      end
    end
  seq_down_cnt #(.W(IW), .TC(0)) u_idx (
    .clk(clk), .rst_n(rst_n),
    .load(go || frame_end || (state_q == GAP && gap_last)),
    .dec(state_q == SEND), .val(IW'(PAT_W - 1)),
    .cnt(idx), .tc(idx_last)
  );
  seq_down_cnt #(.W(CNT_W), .TC(1)) u_reps (
    .clk(clk), .rst_n(rst_n), .load(go), .dec(frame_end && !reps_last),
    .val(rep_cnt == '0 ? CNT_W'(1) : rep_cnt),
    .cnt(reps_left), .tc(reps_last)
  );
  seq_down_cnt #(.W(GAP_W), .TC(1)) u_gap (
    .clk(clk), .rst_n(rst_n), .load(frame_end), .dec(state_q == GAP),
    .val(gap_q), .cnt(gap_left), .tc(gap_last)
  );
  assign unused_cnt = ^{reps_left, gap_left};
  assign dout = state_q == SEND && pat_q[idx];
  assign valid = state_q == SEND;
  assign busy = state_q == SEND || state_q == GAP;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: table-driven and directed checks of seq_pattern_tx with a 1010 loopback detector model
module tb_seq_pattern_tx;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, use_def = 0;
  logic [3:0] pat_in = '0, gap_cnt = '0;
  logic [7:0] rep_cnt = '0;
  logic dout, valid, busy, done;
  int n_cmp = 0, n_err = 0, hits = 0;
  logic [3:0] sh = '0;
  typedef struct {
    logic        use_def;
    logic [3:0]  pat;
    logic [7:0]  rep;
    logic [3:0]  gap;
    int          len;
    logic [31:0] dout;
    logic [31:0] vld;
  } vec_t;
  vec_t vt[6];
  seq_pattern_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .use_def(use_def),
    .pat_in(pat_in), .rep_cnt(rep_cnt), .gap_cnt(gap_cnt),
    .dout(dout), .valid(valid), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    sh <= {sh[2:0], dout};
    if ({sh[2:0], dout} == 4'b1010) hits <= hits + 1;
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic run_burst(input vec_t v, input string nm);
    int n;
    logic [31:0] gd, gv;
    @(negedge clk);
    use_def = v.use_def; pat_in = v.pat; rep_cnt = v.rep; gap_cnt = v.gap; start = 1;
    @(negedge clk);
    start = 0; n = 0; gd = '0; gv = '0;
    while (busy && n < 40) begin
      gd = {gd[30:0], dout};
      gv = {gv[30:0], valid};
      n++;
      @(negedge clk);
    end
    chk({nm, " busy_len"}, n, v.len);
    chk({nm, " dout_seq"}, gd, v.dout);
    chk({nm, " valid_seq"}, gv, v.vld);
    chk({nm, " done_pulse"}, {valid, done}, 2'b01);
    @(negedge clk);
    chk({nm, " done_clear"}, {busy, done}, 2'b00);
  endtask
  initial begin
    int n, h0;
    vt[0] = '{1'b1, 4'h0, 8'd1, 4'd0, 4, 32'b1010, 32'b1111};
    vt[1] = '{1'b1, 4'h0, 8'd3, 4'd2, 16, 32'b1010001010001010, 32'b1111001111001111};
    vt[2] = '{1'b0, 4'b0110, 8'd0, 4'd0, 4, 32'b0110, 32'b1111};
    vt[3] = '{1'b0, 4'b1001, 8'd2, 4'd0, 8, 32'b10011001, 32'b11111111};
    vt[4] = '{1'b0, 4'b1100, 8'd2, 4'd1, 9, 32'b110001100, 32'b111101111};
    vt[5] = '{1'b1, 4'b0111, 8'd1, 4'd5, 4, 32'b1010, 32'b1111};
    #3;
    chk("reset outputs", {dout, valid, busy, done}, 4'b0000);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) run_burst(vt[i], $sformatf("vec%0d", i));
    @(negedge clk);
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("start+abort idle", {dout, valid, busy, done}, 4'b0000);
    use_def = 0; pat_in = 4'b1011; rep_cnt = 8'd4; gap_cnt = 4'd1; start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    chk("abort pre bit", {dout, valid, busy}, 3'b111);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort idle", {dout, valid, busy, done}, 4'b0000);
    @(negedge clk);
    chk("abort no done", {busy, done}, 2'b00);
    run_burst(vt[3], "after_abort");
    @(negedge clk);
    use_def = 1; rep_cnt = 8'd2; gap_cnt = 4'd3; start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    chk("mid gap", {busy, valid, dout}, 3'b100);
    rst_n = 0;
    #1;
    chk("async reset gap", {dout, valid, busy, done}, 4'b0000);
    @(negedge clk);
    rst_n = 1;
    run_burst(vt[0], "after_reset");
    @(negedge clk);
    use_def = 0; pat_in = 4'b1010; rep_cnt = 8'd5; gap_cnt = 4'd1; start = 1; h0 = hits;
    @(negedge clk);
    start = 0; n = 0;
    while (busy && n < 60) begin
      n++;
      if (n == 3) begin
        start = 1; pat_in = 4'b1111; rep_cnt = 8'd1; gap_cnt = 4'd0;
      end else start = (n == 10);
      @(negedge clk);
    end
    start = 0;
    chk("loop busy_len", n, 24);
    chk("loop done", done, 1'b1);
    repeat (2) @(negedge clk);
    chk("loop hits", hits - h0, 5);
    chk("loop idle", {busy, done}, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
